pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 32, setting the width of all count, width, period and timeout values.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on posedge clk.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port pwm_in, input, 4, asynchronous PWM inputs, one per channel (RC receiver or loopback of the PWM generator outputs).
REQ-005 SHALL have port timeout, input, COUNTER_WIDTH, the loss-of-signal limit in clk cycles; 0 disables the limit.
REQ-006 SHALL have ports width0..width3, output, COUNTER_WIDTH each, the last measured high time per channel in clk cycles.
REQ-007 SHALL have port width_valid, output, 4, a one-cycle strobe per channel when that channel's width register updates.
REQ-008 SHALL have port signal_lost, output, 4, a per-channel level flag for loss of signal.
REQ-009 SHALL have ports period0..period3, output, COUNTER_WIDTH each, and period_valid, output, 4 (see REQ-024).

Function
REQ-010 SHALL pass each pwm_in bit through a 2-flop synchronizer, then a 1-flop edge detector; all behaviour is defined on the synchronized signal s.
REQ-011 SHALL run an independent per-channel FSM with states DISARMED, IDLE, HIGH and LOW.
- DISARMED->IDLE when s==0.
- IDLE->HIGH on a rising edge of s.
- HIGH->LOW on a falling edge of s.
- LOW->HIGH on a rising edge of s.
REQ-012 SHALL make the high counter hold 1 in the first cycle s is seen high and increment once per cycle while in HIGH.
REQ-013 SHALL, on a falling edge, load widthN with the number of cycles s was high, and assert width_valid[N] for exactly one cycle.
REQ-014 SHALL give a total latency of 3 clk cycles from a pwm_in falling edge to the width_valid strobe.
REQ-015 SHALL saturate the high counter at all-ones rather than wrap; a saturated width is reported as all-ones.
REQ-016 SHALL count cycles since the last edge in HIGH and LOW; when timeout!=0 and the count reaches timeout:
- set signal_lost[N];
- go to IDLE;
- discard the partial measurement; widthN holds its old value.
REQ-017 SHALL clear signal_lost[N] in the same cycle the next width_valid[N] asserts.
REQ-018 SHALL give a glitch of one synchronized cycle high a width of 1; no minimum-width filtering is applied.
REQ-019 SHALL keep the channels fully independent; simultaneous edges on all 4 channels produce 4 simultaneous strobes.
REQ-020 SHALL hold all output registers between updates.

Reset
REQ-021 SHALL, on reset assertion, immediately:
- clear the synchronizers, counters, widthN, periodN, width_valid, period_valid and signal_lost to 0;
- put every FSM in DISARMED.
REQ-022 SHALL discard a pulse already high at reset release; the first measurement requires a low followed by a full high pulse.
REQ-023 SHALL abort a measurement in progress when reset is asserted mid-pulse, with no strobe.

Configuration
REQ-024 SHALL provide macro PWM_CAPTURE_PERIOD_EN.
- Defined: on each rising edge in LOW, periodN loads the rising-to-rising cycle count (saturating), and period_valid[N] strobes for one cycle. The first rising edge after IDLE produces no period.
- Undefined: periodN and period_valid are tied to 0, and no period counters are synthesized.

Structure
REQ-025 SHALL place the default COUNTER_WIDTH constant and the channel-state enum typedef in the shared package pwm_pkg.
REQ-026 SHALL implement one channel in sub-module pwm_capture_ch, instantiated four times by pwm_capture.

Verification
REQ-027 SHALL cover: pwm_in[0] high for 1000 cycles -> width0==1000 with width_valid[0] 3 cycles after the falling edge.
REQ-028 SHALL cover: period 20000, duty 1500 on all 4 channels, with PWM_CAPTURE_PERIOD_EN -> widthN==1500 and periodN==20000 from the second pulse onward; the 4 strobes are simultaneous.
REQ-029 SHALL cover: timeout=5000, input held low after one pulse -> signal_lost[N]=1 at 5000 cycles; the next 800-cycle pulse sets widthN==800 and clears the flag.
REQ-030 SHALL cover: pwm_in high across reset release -> no width_valid until after a low, then a full 1200-cycle pulse -> 1200.
REQ-031 SHALL cover: COUNTER_WIDTH=8, 300-cycle pulse -> width==255 (saturated).
REQ-032 SHALL cover: rst_n asserted mid-pulse -> all outputs 0 immediately, no strobe emitted.

Source files
------------

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and channel state type for the PWM capture block
package pwm_pkg;

    localparam int unsigned PWM_COUNTER_WIDTH = 32;
    localparam int unsigned PWM_CHANNELS      = 4;

    typedef enum logic [1:0] {
        CH_DISARMED = 2'd0,
        CH_IDLE     = 2'd1,
        CH_HIGH     = 2'd2,
        CH_LOW      = 2'd3
    } ch_state_e;

endpackage

// File: rtl/pwm_capture_ch.sv
// rtl/pwm_capture_ch.sv - one PWM capture channel: synchronizer, edge detect, high-time FSM
// PWM_CAPTURE_PERIOD_EN adds the rising-to-rising period counter.
module pwm_capture_ch
    import pwm_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = PWM_COUNTER_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pwm_in,
    input  logic [COUNTER_WIDTH-1:0] timeout,
    output logic [COUNTER_WIDTH-1:0] width,
    output logic                     width_valid,
    output logic                     signal_lost,
    output logic [COUNTER_WIDTH-1:0] period,
    output logic                     period_valid
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

    logic [1:0]               sync_q;
    logic                     s_prev_q;
    logic [1:0]               ready_q;
    ch_state_e                state_q, state_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNTER_WIDTH-1:0] width_q, width_d;
    logic                     width_valid_q, width_valid_d;
    logic                     lost_q, lost_d;

    logic                     s, rise, fall, timed_out;
    logic [COUNTER_WIDTH-1:0] cnt_inc;

    assign s         = sync_q[1];
    assign rise      = s & ~s_prev_q;
    assign fall      = ~s & s_prev_q;
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    assign timed_out = (timeout != '0) && (cnt_q >= timeout);

    // cnt_q counts cycles since the last edge; in HIGH that is the high time itself.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        width_d       = width_q;
        width_valid_d = 1'b0;
        lost_d        = lost_q;
        unique case (state_q)
            CH_DISARMED: begin
                // s is only meaningful once the synchronizer has refilled after reset
                if (ready_q[1] && !s) state_d = CH_IDLE;
            end
            CH_IDLE: begin
                if (rise) begin
                    state_d = CH_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            CH_HIGH: begin
                if (fall) begin
                    state_d       = CH_LOW;
                    width_d       = cnt_q;
                    width_valid_d = 1'b1;
                    lost_d        = 1'b0;
                    cnt_d         = CNT_ONE;
                end else if (timed_out) begin
                    state_d = CH_IDLE;
                    lost_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            CH_LOW: begin
                if (rise) begin
                    state_d = CH_HIGH;
                    cnt_d   = CNT_ONE;
                end else if (timed_out) begin
                    state_d = CH_IDLE;
                    lost_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = CH_DISARMED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= 2'b00;
            s_prev_q      <= 1'b0;
            ready_q       <= 2'b00;
            state_q       <= CH_DISARMED;
            cnt_q         <= '0;
            width_q       <= '0;
            width_valid_q <= 1'b0;
            lost_q        <= 1'b0;
        end else begin
            sync_q        <= {sync_q[0], pwm_in};
            s_prev_q      <= s;
            ready_q       <= {ready_q[0], 1'b1};
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            width_q       <= width_d;
            width_valid_q <= width_valid_d;
            lost_q        <= lost_d;
        end
    end

    assign width       = width_q;
    assign width_valid = width_valid_q;
    assign signal_lost = lost_q;

`ifdef PWM_CAPTURE_PERIOD_EN
    logic [COUNTER_WIDTH-1:0] per_cnt_q, per_cnt_d;
    logic [COUNTER_WIDTH-1:0] period_q, period_d;
    logic                     period_valid_q, period_valid_d;

    // The first rise after IDLE enters HIGH, not LOW, so it never reports a period.
    always_comb begin
        per_cnt_d      = rise ? CNT_ONE
                              : ((per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CNT_ONE);
        period_d       = period_q;
        period_valid_d = 1'b0;
        if ((state_q == CH_LOW) && rise) begin
            period_d       = per_cnt_q;
            period_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt_q      <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
        end else begin
            per_cnt_q      <= per_cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
`else
    assign period       = '0;
    assign period_valid = 1'b0;
`endif

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - four-channel PWM high-time capture with loss-of-signal detection
// PWM_CAPTURE_PERIOD_EN enables per-channel period measurement.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = PWM_COUNTER_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PWM_CHANNELS-1:0]  pwm_in,
    input  logic [COUNTER_WIDTH-1:0] timeout,
    output logic [COUNTER_WIDTH-1:0] width0,
    output logic [COUNTER_WIDTH-1:0] width1,
    output logic [COUNTER_WIDTH-1:0] width2,
    output logic [COUNTER_WIDTH-1:0] width3,
    output logic [PWM_CHANNELS-1:0]  width_valid,
    output logic [PWM_CHANNELS-1:0]  signal_lost,
    output logic [COUNTER_WIDTH-1:0] period0,
    output logic [COUNTER_WIDTH-1:0] period1,
    output logic [COUNTER_WIDTH-1:0] period2,
    output logic [COUNTER_WIDTH-1:0] period3,
    output logic [PWM_CHANNELS-1:0]  period_valid
);

    logic [COUNTER_WIDTH-1:0] width_a  [PWM_CHANNELS];
    logic [COUNTER_WIDTH-1:0] period_a [PWM_CHANNELS];

    for (genvar i = 0; i < PWM_CHANNELS; i++) begin : g_ch
        pwm_capture_ch #(
            .COUNTER_WIDTH(COUNTER_WIDTH)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .pwm_in       (pwm_in[i]),
            .timeout      (timeout),
            .width        (width_a[i]),
            .width_valid  (width_valid[i]),
            .signal_lost  (signal_lost[i]),
            .period       (period_a[i]),
            .period_valid (period_valid[i])
        );
    end

    assign width0  = width_a[0];
    assign width1  = width_a[1];
    assign width2  = width_a[2];
    assign width3  = width_a[3];
    assign period0 = period_a[0];
    assign period1 = period_a[1];
    assign period2 = period_a[2];
    assign period3 = period_a[3];

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - randomized self-checking bench for pwm_capture against a pulse-level model
module tb_pwm_capture;

    localparam int W = 32;
`ifdef PWM_CAPTURE_PERIOD_EN
    localparam bit PERIOD_EN = 1'b1;
`else
    localparam bit PERIOD_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   pwm = 4'b0;
    logic [W-1:0] timeout = '0;
    logic [W-1:0] width0, width1, width2, width3, period0, period1, period2, period3;
    logic [3:0]   width_valid, signal_lost, period_valid;

    logic [3:0]   pwm8 = 4'b0;
    logic [7:0]   w8_0, w8_1, w8_2, w8_3, p8_0, p8_1, p8_2, p8_3;
    logic [3:0]   wv8, sl8, pv8;

    pwm_capture dut (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm), .timeout(timeout),
        .width0(width0), .width1(width1), .width2(width2), .width3(width3),
        .width_valid(width_valid), .signal_lost(signal_lost),
        .period0(period0), .period1(period1), .period2(period2), .period3(period3),
        .period_valid(period_valid)
    );

    pwm_capture #(.COUNTER_WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm8), .timeout(8'd0),
        .width0(w8_0), .width1(w8_1), .width2(w8_2), .width3(w8_3),
        .width_valid(wv8), .signal_lost(sl8),
        .period0(p8_0), .period1(p8_1), .period2(p8_2), .period3(p8_3),
        .period_valid(pv8)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    int unsigned tmo_q = 0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        tmo_q <= timeout;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] w_of(input int ch);
        case (ch)
            0: return width0;
            1: return width1;
            2: return width2;
            default: return width3;
        endcase
    endfunction

    function automatic logic [W-1:0] p_of(input int ch);
        case (ch)
            0: return period0;
            1: return period1;
            2: return period2;
            default: return period3;
        endcase
    endfunction

    // Model: an input transition driven after edge c is acted on at edge c+3.
    typedef struct {
        int          ch;
        int unsigned t;
        bit          v;
    } ev_s;
    ev_s evq[$];

    bit          m_armed [4];
    bit          m_active[4];
    bit          m_high  [4];
    bit          m_lost  [4];
    int unsigned m_rise  [4];
    int unsigned m_last  [4];
    int unsigned m_width [4];
    int unsigned m_period[4];

    task automatic model_reset();
        evq.delete();
        for (int i = 0; i < 4; i++) begin
            m_armed[i] = 0; m_active[i] = 0; m_high[i] = 0; m_lost[i] = 0;
            m_rise[i] = 0; m_last[i] = 0; m_width[i] = 0; m_period[i] = 0;
        end
    endtask

    task automatic model_arm();
        for (int i = 0; i < 4; i++) m_armed[i] = (pwm[i] == 1'b0);
    endtask

    task automatic set_pin(input int ch, input bit v);
        if (pwm[ch] != v) begin
            pwm[ch] = v;
            if (rst_n) evq.push_back('{ch: ch, t: cyc + 3, v: v});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        bit   hit[4];
        bit   val[4];
        bit   ewv, epv;
        ev_s  e;
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin hit[i] = 0; val[i] = 0; end
            while (evq.size() > 0 && evq[0].t <= cyc) begin
                e = evq.pop_front();
                hit[e.ch] = 1;
                val[e.ch] = e.v;
            end
            for (int ch = 0; ch < 4; ch++) begin
                ewv = 0;
                epv = 0;
                if (hit[ch]) begin
                    if (val[ch]) begin
                        if (m_armed[ch]) begin
                            if (m_active[ch] && !m_high[ch]) begin
                                epv = 1;
                                m_period[ch] = cyc - m_rise[ch];
                            end
                            m_active[ch] = 1; m_high[ch] = 1;
                            m_rise[ch] = cyc; m_last[ch] = cyc;
                        end
                    end else if (!m_armed[ch]) begin
                        m_armed[ch] = 1;
                    end else if (m_active[ch] && m_high[ch]) begin
                        ewv = 1;
                        m_width[ch] = cyc - m_rise[ch];
                        m_lost[ch] = 0; m_high[ch] = 0; m_last[ch] = cyc;
                    end
                end else if (m_active[ch] && tmo_q != 0 && (cyc - m_last[ch]) >= tmo_q) begin
                    m_lost[ch] = 1; m_active[ch] = 0; m_high[ch] = 0;
                end
                chk($sformatf("wv%0d", ch), width_valid[ch], ewv);
                chk($sformatf("lost%0d", ch), signal_lost[ch], m_lost[ch]);
                chk($sformatf("pv%0d", ch), period_valid[ch], epv & PERIOD_EN);
                if (ewv || width_valid[ch])
                    chk($sformatf("width%0d", ch), w_of(ch), m_width[ch]);
                if ((epv && PERIOD_EN) || period_valid[ch])
                    chk($sformatf("period%0d", ch), p_of(ch), PERIOD_EN ? m_period[ch] : 0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_w%0d", tag, i), w_of(i), 0);
            chk($sformatf("%s_p%0d", tag, i), p_of(i), 0);
        end
        chk({tag, "_wv"}, width_valid, 0);
        chk({tag, "_lost"}, signal_lost, 0);
        chk({tag, "_pv"}, period_valid, 0);
        chk({tag, "_w8"}, w8_0, 0);
    endtask

    int unsigned rem[4];

    initial begin
        model_reset();
        idle(3);
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_arm();
        idle(5);

        // 1000-cycle pulse, strobe exactly 3 cycles after the falling edge
        set_pin(0, 1);
        idle(1000);
        set_pin(0, 0);
        idle(2);
        chk("req027_early_wv", width_valid[0], 0);
        idle(1);
        chk("req027_wv", width_valid[0], 1);
        chk("req027_width", width0, 1000);

        // one-cycle glitch
        set_pin(3, 1);
        idle(1);
        set_pin(3, 0);
        idle(3);
        chk("glitch_width", width3, 1);

        // 8-bit instance saturates
        pwm8[0] = 1'b1;
        idle(300);
        pwm8[0] = 1'b0;
        idle(3);
        chk("sat_wv", wv8[0], 1);
        chk("sat_width", w8_0, 255);

        // 20000-cycle period, 1500 duty, all channels together
        for (int p = 0; p < 3; p++) begin
            for (int ch = 0; ch < 4; ch++) set_pin(ch, 1);
            idle(3);
            if (p > 0) begin
                chk("req028_pv_all", period_valid, PERIOD_EN ? 4'hF : 4'h0);
                for (int ch = 0; ch < 4; ch++)
                    chk($sformatf("req028_period%0d", ch), p_of(ch), PERIOD_EN ? 20000 : 0);
            end
            idle(1497);
            for (int ch = 0; ch < 4; ch++) set_pin(ch, 0);
            idle(3);
            chk("req028_wv_all", width_valid, 4'hF);
            for (int ch = 0; ch < 4; ch++)
                chk($sformatf("req028_width%0d", ch), w_of(ch), 1500);
            idle((p < 2) ? 18497 : 7);
        end

        // loss of signal after 5000 quiet cycles, cleared by the next pulse
        timeout = 5000;
        idle(2);
        set_pin(2, 1);
        idle(300);
        set_pin(2, 0);
        idle(5002);
        chk("req029_lost_before", signal_lost[2], 0);
        idle(1);
        chk("req029_lost", signal_lost[2], 1);
        idle(10);
        set_pin(2, 1);
        idle(800);
        set_pin(2, 0);
        idle(3);
        chk("req029_width", width2, 800);
        chk("req029_cleared", signal_lost[2], 0);

        // random independent traffic with a short timeout
        timeout = $urandom_range(80, 40);
        for (int i = 0; i < 4; i++) rem[i] = $urandom_range(20, 1);
        repeat (2500) begin
            @(negedge clk);
            for (int ch = 0; ch < 4; ch++) begin
                rem[ch]--;
                if (rem[ch] == 0) begin
                    set_pin(ch, !pwm[ch]);
                    rem[ch] = pwm[ch] ? $urandom_range(90, 1) : $urandom_range(120, 1);
                end
            end
        end
        @(negedge clk);
        for (int ch = 0; ch < 4; ch++) set_pin(ch, 0);
        idle(300);
        for (int ch = 0; ch < 4; ch++) begin
            chk($sformatf("rand_w%0d", ch), w_of(ch), m_width[ch]);
            chk($sformatf("rand_lost%0d", ch), signal_lost[ch], m_lost[ch]);
        end
        timeout = 0;

        // reset mid-pulse, pulse still high across reset release
        @(negedge clk);
        set_pin(0, 1);
        idle(50);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all_zero("req032");
        idle(5);
        rst_n = 1'b1;
        model_arm();
        idle(100);
        chk("req030_no_wv", width0, 0);
        set_pin(0, 0);
        idle(20);
        set_pin(0, 1);
        idle(1200);
        set_pin(0, 0);
        idle(3);
        chk("req030_wv", width_valid[0], 1);
        chk("req030_width", width0, 1200);
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
